buffer_access_arbiter: RTL
==========================

BUFFER_ACCESS_ARBITER -- requirements
Module: buffer_access_arbiter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 64, meaning data_buffer capacity in bytes.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 SHALL have ports ahb_wr_req, ahb_rd_req, rx_wr_req and tx_rd_req, input, 1 bit each, meaning level requests for host TX store, host RX fetch, USB RX store and USB TX fetch.
REQ-005 SHALL have ports clear_req and flush_req, input, 1 bit each, meaning host clear request and protocol flush request.
REQ-006 SHALL have port Buffer_Occupancy, input, 7 bits, meaning data_buffer byte count.
REQ-007 SHALL have ports Store_TX_Data, Get_RX_Data, Store_RX_Packet_Data, Get_TX_Packet_Data, Clear and Flush, output, 1 bit each, meaning data_buffer strobes.
REQ-008 SHALL have ports ahb_wr_ack, ahb_rd_ack, rx_wr_ack and tx_rd_ack, output, 1 bit each, meaning per-requester grant pulses.
REQ-009 SHALL have ports ahb_wr_err, ahb_rd_err, rx_wr_err and tx_rd_err, output, 1 bit each, meaning per-requester overflow/underflow reject pulses.
REQ-010 SHALL have ports buf_full and buf_empty, output, 1 bit each, meaning occupancy == BUF_DEPTH and occupancy == 0.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, SETTLE and PURGE.
REQ-012 In IDLE with clear_req or flush_req high, SHALL go to PURGE.
REQ-013 In PURGE, SHALL assert Clear (if clear_req was sampled) and/or Flush (if flush_req was sampled) for exactly one cycle, then go to SETTLE; both SHALL pulse together when both were sampled.
REQ-014 In IDLE with no purge request, SHALL grant one request in priority order: rx_wr_req, tx_rd_req, then the AHB pair under round robin.
REQ-015 AHB round robin: the pointer SHALL reset to ahb_wr, SHALL flip to the other AHB requester after each AHB ack or err, and SHALL NOT change on USB grants.
REQ-016 A winning store request with buf_full high SHALL produce a one-cycle err pulse, with no strobe and no ack, then SETTLE.
REQ-017 A winning fetch request with buf_empty high SHALL produce a one-cycle err pulse, with no strobe and no ack, then SETTLE.
REQ-018 Otherwise IDLE SHALL go to ACCESS, where the matching strobe and ack are asserted together for exactly one cycle; then SETTLE.
REQ-019 SETTLE SHALL last one cycle, ignore all requests, and return to IDLE; peak throughput is one access per 3 cycles.
REQ-020 Strobes, acks and errs SHALL be registered outputs; at most one data strobe SHALL be high in any cycle.
REQ-021 Request-to-strobe latency from IDLE SHALL be 1 cycle; the strobe SHALL be high in the cycle after the request is sampled.
REQ-022 Requesters drop req in the cycle after ack/err; a req still high in IDLE after SETTLE SHALL be treated as a new request.
REQ-023 A purge request arriving during ACCESS or SETTLE SHALL be held pending and served at the next IDLE ahead of all data requests.
REQ-024 Pending data requests SHALL survive a purge; store grants resume after it, and fetch grants err while empty.
REQ-025 buf_full and buf_empty SHALL be combinational from Buffer_Occupancy.

Reset
REQ-026 On n_rst low, SHALL immediately set state to IDLE, all strobes/acks/errs to 0, round-robin pointer to ahb_wr, and pending purge flags to 0, including mid-ACCESS.

Structure
REQ-027 The shared usb_pkg SHALL hold the FSM state enum, the requester-ID enum and the BUF_DEPTH default constant.
REQ-028 SHALL contain one sub-module, rr_arb2, the two-way round-robin arbiter for the AHB pair; all other logic is flat.

Verification
REQ-029 Reset, then rx_wr_req high with occupancy 0 -> Store_RX_Packet_Data and rx_wr_ack high one cycle later for 1 cycle; SETTLE; IDLE on cycle 4.
REQ-030 ahb_wr_req and ahb_rd_req held high, occupancy 10 -> grant order wr, rd, wr, rd at 3-cycle spacing.
REQ-031 rx_wr_req and ahb_wr_req raised the same cycle -> rx_wr_ack first; ahb_wr_ack 3 cycles later.
REQ-032 Occupancy 64 with ahb_wr_req -> ahb_wr_err pulse, no Store_TX_Data; occupancy 0 with tx_rd_req -> tx_rd_err, no Get_TX_Packet_Data.
REQ-033 flush_req asserted during ACCESS of tx_rd -> tx_rd_ack completes, Flush pulses at the next IDLE+1 ahead of a pending ahb_rd_req; clear_req with flush_req together -> Clear and Flush in the same cycle.
REQ-034 n_rst asserted mid-ACCESS -> all outputs 0 asynchronously; the first AHB grant after release goes to ahb_wr.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types for the USB data_buffer access path: FSM states, requester IDs
// and the default buffer capacity.
package usb_pkg;

  localparam int BUF_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SETTLE,
    PURGE
  } arb_state_t;

  typedef enum logic [1:0] {
    RQ_RX_WR,
    RQ_TX_RD,
    RQ_AHB_WR,
    RQ_AHB_RD
  } req_id_t;

endpackage

// File: rtl/buffer_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter for the AHB store/fetch pair; the pointer only
// moves when the owning FSM reports that an AHB requester was served.
module rr_arb2
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  req_id_t ptr;

  // Pointer names the AHB requester favoured when both are asking.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == RQ_AHB_RD) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= RQ_AHB_WR;
    end else if (update) begin
      ptr <= gnt[0] ? RQ_AHB_RD : RQ_AHB_WR;
    end
  end

endmodule

// File: rtl/buffer_access_arbiter.sv
// Arbitrates AHB and USB-side access to the shared data_buffer, issuing one
// registered strobe/ack (or err) per access plus clear/flush purges.
module buffer_access_arbiter
  import usb_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ahb_wr_req,
  input  logic       ahb_rd_req,
  input  logic       rx_wr_req,
  input  logic       tx_rd_req,
  input  logic       clear_req,
  input  logic       flush_req,
  input  logic [6:0] Buffer_Occupancy,
  output logic       Store_TX_Data,
  output logic       Get_RX_Data,
  output logic       Store_RX_Packet_Data,
  output logic       Get_TX_Packet_Data,
  output logic       Clear,
  output logic       Flush,
  output logic       ahb_wr_ack,
  output logic       ahb_rd_ack,
  output logic       rx_wr_ack,
  output logic       tx_rd_ack,
  output logic       ahb_wr_err,
  output logic       ahb_rd_err,
  output logic       rx_wr_err,
  output logic       tx_rd_err,
  output logic       buf_full,
  output logic       buf_empty
);

  arb_state_t state;
  req_id_t    win;
  logic       has_req;
  logic       blocked;
  logic       purge_now;
  logic       pend_clear;
  logic       pend_flush;
  logic       ahb_update;
  logic [1:0] ahb_gnt;

  assign buf_full  = (Buffer_Occupancy == 7'(BUF_DEPTH));
  assign buf_empty = (Buffer_Occupancy == 7'd0);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .n_rst  (n_rst),
    .req    ({ahb_rd_req, ahb_wr_req}),
    .update (ahb_update),
    .gnt    (ahb_gnt)
  );

  // USB requesters outrank the AHB pair; blocked means the winner would
  // overflow (store) or underflow (fetch) the buffer.
  always_comb begin
    has_req = 1'b1;
    win     = RQ_RX_WR;
    if (rx_wr_req)       win = RQ_RX_WR;
    else if (tx_rd_req)  win = RQ_TX_RD;
    else if (ahb_gnt[0]) win = RQ_AHB_WR;
    else if (ahb_gnt[1]) win = RQ_AHB_RD;
    else                 has_req = 1'b0;
    blocked    = (win == RQ_RX_WR || win == RQ_AHB_WR) ? buf_full : buf_empty;
    purge_now  = clear_req | flush_req | pend_clear | pend_flush;
    ahb_update = (state == IDLE) && !purge_now && has_req &&
                 (win == RQ_AHB_WR || win == RQ_AHB_RD);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= IDLE;
      pend_clear           <= 1'b0;
      pend_flush           <= 1'b0;
      Store_TX_Data        <= 1'b0;
      Get_RX_Data          <= 1'b0;
      Store_RX_Packet_Data <= 1'b0;
      Get_TX_Packet_Data   <= 1'b0;
      Clear                <= 1'b0;
      Flush                <= 1'b0;
      ahb_wr_ack           <= 1'b0;
      ahb_rd_ack           <= 1'b0;
      rx_wr_ack            <= 1'b0;
      tx_rd_ack            <= 1'b0;
      ahb_wr_err           <= 1'b0;
      ahb_rd_err           <= 1'b0;
      rx_wr_err            <= 1'b0;
      tx_rd_err            <= 1'b0;
    end else begin
      Store_TX_Data        <= 1'b0;
      Get_RX_Data          <= 1'b0;
      Store_RX_Packet_Data <= 1'b0;
      Get_TX_Packet_Data   <= 1'b0;
      Clear                <= 1'b0;
      Flush                <= 1'b0;
      ahb_wr_ack           <= 1'b0;
      ahb_rd_ack           <= 1'b0;
      rx_wr_ack            <= 1'b0;
      tx_rd_ack            <= 1'b0;
      ahb_wr_err           <= 1'b0;
      ahb_rd_err           <= 1'b0;
      rx_wr_err            <= 1'b0;
      tx_rd_err            <= 1'b0;
      case (state)
        IDLE: begin
          if (purge_now) begin
            Clear      <= clear_req | pend_clear;
            Flush      <= flush_req | pend_flush;
            pend_clear <= 1'b0;
            pend_flush <= 1'b0;
            state      <= PURGE;
          end else if (has_req && blocked) begin
            case (win)
              RQ_RX_WR:  rx_wr_err  <= 1'b1;
              RQ_TX_RD:  tx_rd_err  <= 1'b1;
              RQ_AHB_WR: ahb_wr_err <= 1'b1;
              default:   ahb_rd_err <= 1'b1;
            endcase
            state <= SETTLE;
          end else if (has_req) begin
            case (win)
              RQ_RX_WR: begin
                Store_RX_Packet_Data <= 1'b1;
                rx_wr_ack            <= 1'b1;
              end
              RQ_TX_RD: begin
                Get_TX_Packet_Data <= 1'b1;
                tx_rd_ack          <= 1'b1;
              end
              RQ_AHB_WR: begin
                Store_TX_Data <= 1'b1;
                ahb_wr_ack    <= 1'b1;
              end
              default: begin
                Get_RX_Data <= 1'b1;
                ahb_rd_ack  <= 1'b1;
              end
            endcase
            state <= ACCESS;
          end
        end
        // Purge requests seen mid-access are remembered for the next IDLE.
        ACCESS: begin
          pend_clear <= pend_clear | clear_req;
          pend_flush <= pend_flush | flush_req;
          state      <= SETTLE;
        end
        SETTLE: begin
          pend_clear <= pend_clear | clear_req;
          pend_flush <= pend_flush | flush_req;
          state      <= IDLE;
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule
